// File: rtl/mem_arbiter_ram.sv
// mem_arbiter_ram: round-robin multi-port front end over a single-port synchronous RAM (optional MEM_RANGE_CHECK_EN adds err/err_addr)
module mem_arbiter_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int NUM_PORTS  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             readwriteN,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data_in,
  output logic [NUM_PORTS-1:0]             ack,
  output logic [DATA_WIDTH-1:0]            data_out
`ifdef MEM_RANGE_CHECK_EN
  ,
  output logic                             err,
  output logic [ADDR_WIDTH-1:0]            err_addr
`endif
);
  localparam int PW = $clog2(NUM_PORTS);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic [PW-1:0] rr_ptr, grant, win;
  logic [PW:0] s;
  logic found, g_rw, in_range;
  logic [NUM_PORTS-1:0] elig;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  assign elig = req & ~ack;
  assign in_range = 32'(g_addr) < DEPTH;
  // round-robin search: the eligible port closest to rr_ptr wins, so scan from the far end down
  always_comb begin
    win = rr_ptr;
    found = 1'b0;
    s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      s = {1'b0, rr_ptr} + (PW+1)'(i);
      if (s >= (PW+1)'(NUM_PORTS)) s = s - (PW+1)'(NUM_PORTS);
      if (elig[s[PW-1:0]]) begin
        win = s[PW-1:0];
        found = 1'b1;
      end
    end
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // every access takes exactly one ACCESS cycle, then back to IDLE
  always_comb state_n = (state == IDLE) ? (found ? ACCESS : IDLE) : IDLE;
  // capture the winner's operands at the grant edge; later input changes are ignored
  always_ff @(posedge clk)
    if (state == IDLE && found) begin
      grant  <= win;
      g_rw   <= readwriteN[win];
      g_addr <= address[win*ADDR_WIDTH +: ADDR_WIDTH];
      g_data <= data_in[win*DATA_WIDTH +: DATA_WIDTH];
    end
  // ack pulse, read data and pointer advance; reset drops an access scheduled at the same edge
  always_ff @(posedge clk)
    if (rst) begin
      ack      <= '0;
      data_out <= '0;
      rr_ptr   <= '0;
    end else if (state == IDLE) begin
      ack <= '0;
    end else begin
      ack    <= NUM_PORTS'(1) << grant;
      rr_ptr <= (32'(grant) == NUM_PORTS - 1) ? '0 : grant + 1'b1;
      if (!g_rw) data_out <= in_range ? mem[g_addr] : '0;
    end
  // RAM write port; out-of-range writes are discarded and contents survive reset
  always_ff @(posedge clk)
    if (!rst && state == ACCESS && g_rw && in_range) mem[g_addr] <= g_data;
`ifdef MEM_RANGE_CHECK_EN
  // range error pulses alongside the ack; the offending address is sticky until reset
  always_ff @(posedge clk)
    if (rst) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      err <= state == ACCESS && !in_range;
      if (state == ACCESS && !in_range) err_addr <= g_addr;
    end
`endif
endmodule

// File: tb/tb_mem_arbiter_ram.sv
// tb_mem_arbiter_ram: table-driven and scoreboarded checks of the arbitrated RAM
module tb_mem_arbiter_ram;
  localparam int DW = 16, AW = 5, D = 24, NP = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [NP-1:0] req = '0, rw = '0, ack;
  logic [NP*AW-1:0] address = '0;
  logic [NP*DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
`ifdef MEM_RANGE_CHECK_EN
  logic err;
  logic [AW-1:0] err_addr;
`endif
  mem_arbiter_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .NUM_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .req(req), .readwriteN(rw), .address(address),
    .data_in(data_in), .ack(ack), .data_out(data_out)
`ifdef MEM_RANGE_CHECK_EN
    , .err(err), .err_addr(err_addr)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    int port;
    logic w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_d;
    logic exp_err;
  } vec_t;
  typedef struct {
    logic [NP-1:0] ack;
    logic [DW-1:0] d;
    logic err;
  } exp_t;
  exp_t sb[$];
  int passed = 0, total = 0;
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic drive(int p, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    req[p] = 1'b1;
    rw[p] = w;
    address[p*AW +: AW] = a;
    data_in[p*DW +: DW] = d;
  endtask
  task automatic push(int p, logic [DW-1:0] d, logic er);
    exp_t e;
    e.ack = NP'(1) << p;
    e.d = d;
    e.err = er;
    sb.push_back(e);
  endtask
  task automatic compare_ack(string name);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: got unexpected ack %b expected none", name, ack);
      return;
    end
    e = sb.pop_front();
    check({name, " ack"}, 32'(ack), 32'(e.ack));
    check({name, " data_out"}, 32'(data_out), 32'(e.d));
`ifdef MEM_RANGE_CHECK_EN
    check({name, " err"}, 32'(err), 32'(e.err));
`endif
  endtask
  task automatic xact(int p, logic w, logic [AW-1:0] a, logic [DW-1:0] wd, logic [DW-1:0] ed, logic er);
    int n = 0;
    drive(p, w, a, wd);
    push(p, ed, er);
    do begin
      tick();
      n++;
    end while (ack == '0 && n < 8);
    req[p] = 1'b0;
    check("latency", 32'(n), 32'd2);
    if (ack != '0) compare_ack("xact");
    else sb.delete();
    tick();
    check("ack clear", 32'(ack), 32'd0);
  endtask
  vec_t tbl[11];
  initial begin
    int n, acks, f, s;
    logic [AW-1:0] ea;
    tbl[0]  = '{0, 1'b1, 5'd3,  16'hBEEF, 16'h0000, 1'b0};
    tbl[1]  = '{1, 1'b0, 5'd3,  16'h0000, 16'hBEEF, 1'b0};
    tbl[2]  = '{2, 1'b1, 5'd23, 16'h5A5A, 16'hBEEF, 1'b0};
    tbl[3]  = '{3, 1'b0, 5'd23, 16'h0000, 16'h5A5A, 1'b0};
    tbl[4]  = '{0, 1'b1, 5'd7,  16'h0777, 16'h5A5A, 1'b0};
    tbl[5]  = '{1, 1'b0, 5'd7,  16'h0000, 16'h0777, 1'b0};
    tbl[6]  = '{2, 1'b1, 5'd30, 16'hFFFF, 16'h0777, 1'b1};
    tbl[7]  = '{3, 1'b0, 5'd30, 16'h0000, 16'h0000, 1'b1};
    tbl[8]  = '{0, 1'b0, 5'd24, 16'h0000, 16'h0000, 1'b1};
    tbl[9]  = '{1, 1'b1, 5'd0,  16'h0002, 16'h0000, 1'b0};
    tbl[10] = '{2, 1'b0, 5'd0,  16'h0000, 16'h0002, 1'b0};
    do_reset();
    check("reset ack", 32'(ack), 32'd0);
    check("reset data_out", 32'(data_out), 32'd0);
`ifdef MEM_RANGE_CHECK_EN
    check("reset err", 32'(err), 32'd0);
    check("reset err_addr", 32'(err_addr), 32'd0);
`endif
    ea = '0;
    for (int i = 0; i < 11; i++) begin
      xact(tbl[i].port, tbl[i].w, tbl[i].addr, tbl[i].wd, tbl[i].exp_d, tbl[i].exp_err);
      if (tbl[i].exp_err) ea = tbl[i].addr;
`ifdef MEM_RANGE_CHECK_EN
      check("err_addr", 32'(err_addr), 32'(ea));
`endif
    end
    do_reset();
    drive(0, 1'b1, 5'd0, 16'h0001);
    drive(1, 1'b0, 5'd0, 16'h0000);
    push(0, 16'h0000, 1'b0);
    push(1, 16'h0001, 1'b0);
    push(0, 16'h0001, 1'b0);
    push(1, 16'h0001, 1'b0);
    n = 0;
    acks = 0;
    while (acks < 4 && n < 20) begin
      tick();
      n++;
      if (ack != '0) begin
        check("contend onehot", 32'($onehot(ack)), 32'd1);
        compare_ack("contend");
        acks++;
      end
    end
    req = '0;
    check("contend count", 32'(acks), 32'd4);
    tick();
    drive(0, 1'b0, 5'd3, 16'h0000);
    push(0, 16'hBEEF, 1'b0);
    push(0, 16'hBEEF, 1'b0);
    acks = 0;
    f = 0;
    s = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack != '0) begin
        compare_ack("mask");
        if (acks == 0) f = c;
        else s = c;
        acks++;
      end
      if (acks == 1 && c == f + 2) req[0] = 1'b0;
    end
    req = '0;
    check("mask count", 32'(acks), 32'd2);
    check("mask spacing", 32'(s - f), 32'd3);
    drive(2, 1'b1, 5'd7, 16'h1234);
    tick();
    req = '0;
    rst = 1'b1;
    tick();
    check("rst mid ack", 32'(ack), 32'd0);
    check("rst mid data_out", 32'(data_out), 32'd0);
    rst = 1'b0;
    tick();
    check("rst mid ack later", 32'(ack), 32'd0);
    xact(3, 1'b0, 5'd7, 16'h0000, 16'h0777, 1'b0);
    do_reset();
    drive(0, 1'b0, 5'd3, 16'h0000);
    drive(1, 1'b0, 5'd23, 16'h0000);
    drive(2, 1'b0, 5'd7, 16'h0000);
    drive(3, 1'b0, 5'd0, 16'h0000);
    push(0, 16'hBEEF, 1'b0);
    push(1, 16'h5A5A, 1'b0);
    push(2, 16'h0777, 1'b0);
    push(3, 16'h0001, 1'b0);
    push(0, 16'hBEEF, 1'b0);
    n = 0;
    acks = 0;
    while (acks < 5 && n < 30) begin
      tick();
      n++;
      if (ack != '0) begin
        compare_ack("rotate");
        acks++;
      end
    end
    req = '0;
    check("rotate count", 32'(acks), 32'd5);
    tick();
    tick();
    check("rotate idle ack", 32'(ack), 32'd0);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
